// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester memory arbiter: I/D line fills and D single-word writes
module mem_arbiter #(
  parameter int unsigned WAIT_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_fill_vld,
  output logic        d_fill_vld,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  localparam logic       OWN_I = 1'b0;
  localparam logic       OWN_D = 1'b1;
  localparam logic [2:0] WLAST = 3'(WAIT_CYC);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last_grant, last_grant_nx;
  logic [2:0]  wcnt, wcnt_nx;
  logic [2:0]  cyc, cyc_nx;
  logic [15:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic        win;
  logic        word_end;

  // Sub-word/sub-line address bits are dropped by the alignment below.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[3:0], d_addr[0]};

  assign word_end  = (cyc == WLAST);
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      wcnt       <= 3'd0;
      cyc        <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      wcnt       <= wcnt_nx;
      cyc        <= cyc_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    wcnt_nx       = wcnt;
    cyc_nx        = cyc;
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    win           = OWN_I;
    i_fill_vld    = 1'b0;
    d_fill_vld    = 1'b0;
    fill_word     = 3'd0;
    fill_data     = 16'h0000;
    i_done        = 1'b0;
    d_done        = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // On a tie the side that did not win last time goes first.
          win           = (i_req && d_req) ? ~last_grant : d_req;
          owner_nx      = win;
          last_grant_nx = win;
          wcnt_nx       = 3'd0;
          cyc_nx        = 3'd0;
          if (win == OWN_D) begin
            wdata_nx = d_wdata;
            if (d_wr) begin
              addr_nx  = {d_addr[15:1], 1'b0};
              state_nx = WRITE;
            end else begin
              addr_nx  = {d_addr[15:4], 4'b0000};
              state_nx = FILL;
            end
          end else begin
            addr_nx  = {i_addr[15:4], 4'b0000};
            state_nx = FILL;
          end
        end
      end

      FILL: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + {12'h000, wcnt, 1'b0};
        if (word_end) begin
          i_fill_vld = (owner == OWN_I);
          d_fill_vld = (owner == OWN_D);
          fill_word  = wcnt;
          fill_data  = mem_rdata;
          cyc_nx     = 3'd0;
          wcnt_nx    = wcnt + 3'd1;
          if (wcnt == 3'd7) begin
            i_done   = (owner == OWN_I);
            d_done   = (owner == OWN_D);
            state_nx = IDLE;
          end
        end else begin
          cyc_nx = cyc + 3'd1;
        end
      end

      WRITE: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        if (word_end) begin
          mem_wr   = 1'b1;
          d_done   = 1'b1;
          cyc_nx   = 3'd0;
          state_nx = IDLE;
        end else begin
          cyc_nx = cyc + 3'd1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter (WAIT_CYC=3 and WAIT_CYC=0 instances)
module tb_mem_arbiter;

  typedef logic [56:0] obs_t;

  typedef struct {
    logic        rst;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        en;
    logic        wr;
    logic        dd;
    logic [15:0] maddr;
    logic [15:0] mwdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;

  logic        i_fill_vld_a, d_fill_vld_a, i_done_a, d_done_a, mem_en_a, mem_wr_a;
  logic [2:0]  fill_word_a;
  logic [15:0] fill_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        i_fill_vld_b, d_fill_vld_b, i_done_b, d_done_b, mem_en_b, mem_wr_b;
  logic [2:0]  fill_word_b;
  logic [15:0] fill_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  assign mem_rdata_a = mem_addr_a ^ 16'hA5A5;
  assign mem_rdata_b = mem_addr_b ^ 16'hA5A5;

  mem_arbiter #(.WAIT_CYC(3)) dut_a (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_fill_vld(i_fill_vld_a), .d_fill_vld(d_fill_vld_a),
    .fill_word(fill_word_a), .fill_data(fill_data_a), .i_done(i_done_a), .d_done(d_done_a),
    .mem_en(mem_en_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a)
  );

  mem_arbiter #(.WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_fill_vld(i_fill_vld_b), .d_fill_vld(d_fill_vld_b),
    .fill_word(fill_word_b), .fill_data(fill_data_b), .i_done(i_done_b), .d_done(d_done_b),
    .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {i_fill_vld_a, d_fill_vld_a, fill_word_a, fill_data_a, i_done_a, d_done_a,
                  mem_en_a, mem_wr_a, mem_addr_a, mem_wdata_a};
  assign obs_b = {i_fill_vld_b, d_fill_vld_b, fill_word_b, fill_data_b, i_done_b, d_done_b,
                  mem_en_b, mem_wr_b, mem_addr_b, mem_wdata_b};

  int nvec  = 0;
  int nfail = 0;

  function automatic obs_t mk(input logic ifv, input logic dfv, input logic [2:0] fw,
                              input logic [15:0] fd, input logic id, input logic dd,
                              input logic en, input logic wr, input logic [15:0] ad,
                              input logic [15:0] wd);
    return {ifv, dfv, fw, fd, id, dd, en, wr, ad, wd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int who);
    who = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (i_done_a) begin who = 1; break; end
      if (d_done_a) begin who = 2; break; end
    end
  endtask

  vec_t tbl[7];

  initial begin
    int          who;
    int          nv;
    logic [2:0]  w;
    logic        v;
    logic [15:0] ad;
    obs_t        exp;

    // Each row: inputs driven for one cycle, expected outputs after the following edge.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0041, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0040, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h5555};

    rst = 1'b1; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst; d_req = tbl[i].d_req; d_wr = tbl[i].d_wr;
      d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      tick();
      exp = mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, tbl[i].dd, tbl[i].en, tbl[i].wr,
               tbl[i].maddr, tbl[i].mwdata);
      check($sformatf("dwr_vec%0d", i), 64'(obs_a), 64'(exp));
    end

    // I fill alone; request dropped mid-fill must still complete.
    rst = 1'b1; d_req = 1'b0; tick();
    rst = 1'b0; i_req = 1'b1; i_addr = 16'h1236;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 5) i_req = 1'b0;
      if (c <= 32) begin
        w   = 3'((c - 1) / 4);
        v   = ((c - 1) % 4) == 3;
        ad  = 16'h1230 + {12'h0, w, 1'b0};
        exp = mk(v, 1'b0, v ? w : 3'd0, v ? (ad ^ 16'hA5A5) : 16'h0, c == 32, 1'b0,
                 1'b1, 1'b0, ad, 16'h0);
      end else begin
        exp = '0;
      end
      check($sformatf("ifill_c%0d", c), 64'(obs_a), 64'(exp));
    end

    // Ties: D first after reset, then I, then D again.
    rst = 1'b1; tick();
    rst = 1'b0; i_req = 1'b1; i_addr = 16'h2000;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hCAFE;
    wait_done(who); check("tie_first_d", 64'(who), 64'd2);
    wait_done(who); check("tie_then_i", 64'(who), 64'd1);
    wait_done(who); check("tie_again_d", 64'(who), 64'd2);
    i_req = 1'b0; d_req = 1'b0;

    // Reset after the third fill word abandons the fill; re-request restarts at word 0.
    rst = 1'b1; tick();
    rst = 1'b0; i_req = 1'b1; i_addr = 16'h4008;
    nv = 0;
    for (int k = 0; k < 40 && nv < 3; k++) begin
      tick();
      if (i_fill_vld_a) nv++;
    end
    check("rm_three_words", 64'(nv), 64'd3);
    rst = 1'b1; tick();
    check("rm_outputs_zero", 64'(obs_a), 64'd0);
    rst = 1'b0; tick();
    check("rm_restart", 64'(obs_a),
          64'(mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0)));
    tick(); tick(); tick();
    check("rm_word0", 64'(obs_a),
          64'(mk(1'b1, 1'b0, 3'd0, 16'h4000 ^ 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0)));
    i_req = 1'b0;

    // WAIT_CYC=0: back-to-back D fill then I fill with one idle cycle between.
    rst = 1'b1; tick();
    rst = 1'b0; i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; d_wdata = 16'h7777;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c <= 8) begin
        w   = 3'(c - 1);
        ad  = 16'h0020 + {12'h0, w, 1'b0};
        exp = mk(1'b0, 1'b1, w, ad ^ 16'hA5A5, 1'b0, c == 8, 1'b1, 1'b0, ad, 16'h7777);
      end else if (c >= 10 && c <= 17) begin
        w   = 3'(c - 10);
        ad  = 16'h0010 + {12'h0, w, 1'b0};
        exp = mk(1'b1, 1'b0, w, ad ^ 16'hA5A5, c == 17, 1'b0, 1'b1, 1'b0, ad, 16'h7777);
      end else begin
        exp = mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h7777);
      end
      check($sformatf("w0_c%0d", c), 64'(obs_b), 64'(exp));
      if (c == 17) begin i_req = 1'b0; d_req = 1'b0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 3: extra wait cycles per memory word access (range 0..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_req  input  1  instruction-side line-fill request, held until i_done.
REQ-005 SHALL have port i_addr  input  16  instruction miss byte address.
REQ-006 SHALL have port d_req  input  1  data-side request, held until d_done.
REQ-007 SHALL have port d_wr  input  1  data-side request type: 1 = single-word write, 0 = line fill.
REQ-008 SHALL have port d_addr  input  16  data-side byte address.
REQ-009 SHALL have port d_wdata  input  16  data-side write data.
REQ-010 SHALL have port i_fill_vld  output  1  fill word valid for I-side.
REQ-011 SHALL have port d_fill_vld  output  1  fill word valid for D-side.
REQ-012 SHALL have port fill_word  output  3  word index within the line, shared by both requesters.
REQ-013 SHALL have port fill_data  output  16  fill word data, shared by both requesters.
REQ-014 SHALL have port i_done  output  1  one-cycle pulse marking I transaction completion.
REQ-015 SHALL have port d_done  output  1  one-cycle pulse marking D transaction completion.
REQ-016 SHALL have port mem_en  output  1  memory enable.
REQ-017 SHALL have port mem_wr  output  1  memory write strobe.
REQ-018 SHALL have port mem_addr  output  16  memory byte address; bit 0 always 0.
REQ-019 SHALL have port mem_wdata  output  16  memory write data.
REQ-020 SHALL have port mem_rdata  input  16  memory read data, combinational from mem_addr.

Function
REQ-021 SHALL implement an FSM with states IDLE, FILL and WRITE, plus registers owner (I/D), word counter wcnt[2:0], wait counter cyc[2:0] and last_grant.
REQ-022 SHALL, in IDLE with only one requester asserting req, grant that requester; with both asserting, grant the one not equal to last_grant.
REQ-023 SHALL, on grant, set last_grant to the winner and latch the address, wr flag and wdata; the grant becomes effective on the next cycle.
REQ-024 SHALL, for a line fill, latch base = {addr[15:4], 4'b0} and enter FILL; for a D write, latch {d_addr[15:1], 1'b0} and enter WRITE.
REQ-025 SHALL, in FILL, drive mem_en=1, mem_wr=0 and mem_addr = base + {wcnt, 1'b0}, holding each word for WAIT_CYC+1 cycles.
REQ-026 SHALL, in FILL when cyc==WAIT_CYC, pulse the owner's fill_vld with fill_data=mem_rdata and fill_word=wcnt, then clear cyc and increment wcnt.
REQ-027 SHALL, in FILL when wcnt==7 and cyc==WAIT_CYC, pulse the owner's done in the same cycle as the last fill_vld and return to IDLE.
REQ-028 SHALL, in WRITE, drive mem_en=1 for WAIT_CYC+1 cycles, with mem_wr=1 and d_done pulsed only on the final cycle, then return to IDLE.
REQ-029 SHALL drive mem_wdata from the latched wdata at all times.
REQ-030 SHALL drive mem_en=0 and mem_wr=0 in IDLE, giving at least one idle cycle between transactions.
REQ-031 SHALL ignore requests that deassert mid-transaction: the transaction completes and done still pulses.
REQ-032 SHALL ignore new requests and changes on address/data inputs while not in IDLE.
REQ-033 SHALL hold fill_data and fill_word at 0 when no fill_vld is asserted.
REQ-034 SHALL allow a requester still asserting req in the cycle after its done to be re-arbitrated from IDLE.

Reset
REQ-035 SHALL, while rst=1 at a clock edge, set state=IDLE, wcnt=0, cyc=0 and last_grant=I, and drive all outputs to 0.
REQ-036 SHALL abandon an in-flight transaction on reset without pulsing done or fill_vld; the requester re-requests afterwards.

Verification
REQ-037 SHALL verify I fill alone: WAIT_CYC=3, i_addr=0x1236 -> mem_addr steps 0x1230..0x123E every 4 cycles, 8 i_fill_vld with fill_word 0..7, i_done with the 8th, 33 cycles after the request edge.
REQ-038 SHALL verify D write: d_wr=1, d_addr=0x0041, d_wdata=0xBEEF -> mem_addr=0x0040, mem_wr high only on the 4th WRITE cycle, d_done pulses that cycle.
REQ-039 SHALL verify simultaneous requests after reset: i_req and d_req both high -> D served first (last_grant=I), then I; a second tie after that grants D again.
REQ-040 SHALL verify reset mid-fill: rst asserted after the 3rd fill word -> next cycle all outputs 0, no done; a re-request restarts at word 0.
REQ-041 SHALL verify WAIT_CYC=0: 8-word fill completes in 8 FILL cycles, and mem_en is low for at least one cycle between back-to-back transactions.
